// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, STATUS bit positions and I/O window default
package uart_mmio_pkg;
  localparam logic [31:0] IO_BASE_DEF = 32'h8000_0000;
  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RX      = 8'h04;
  localparam logic [7:0] OFF_TX      = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTRET = 8'h14;
  localparam logic [7:0] OFF_CTR_RST = 8'h18;
  localparam int ST_TX_SPACE = 0;
  localparam int ST_RX_AVAIL = 1;
  localparam int ST_OVERFLOW = 2;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: power-of-two byte FIFO with wrap-bit pointers for full/empty
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr[AW-1:0]];
  // pointer advance; reset discards contents by collapsing the pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  // storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: CPU load/store bridge to the UART plus cycle/instret counters
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  logic sel, wr_tx, wr_ctr, rd_rx, tx_free;
  logic [7:0] off, head;
  logic full, empty, overflow;
  logic [31:0] cycle, instret, status, rd_mux;
  logic unused_ok;
  assign unused_ok = ^wdata[31:8];
  assign sel = addr[31:8] == IO_BASE[31:8];
  assign off = addr[7:0];
  assign wr_tx = we && sel && off == OFF_TX;
  assign wr_ctr = we && sel && off == OFF_CTR_RST;
  assign rd_rx = re && sel && off == OFF_RX;
  assign tx_free = !tx_valid || tx_ready;
  assign rx_ready = !full;
  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .push(rx_valid && rx_ready),
    .din(rx_data),
    .pop(rd_rx && !empty),
    .head(head),
    .full(full),
    .empty(empty)
  );
  // STATUS image and load-data mux; empty FIFO reads as zero
  always_comb begin
    status = '0;
    status[ST_TX_SPACE] = !tx_valid;
    status[ST_RX_AVAIL] = !empty;
    status[ST_OVERFLOW] = overflow;
    rd_mux = !sel ? 32'h0 :
             off == OFF_STATUS  ? status :
             off == OFF_RX      ? {24'h0, empty ? 8'h0 : head} :
             off == OFF_CYCLE   ? cycle :
             off == OFF_INSTRET ? instret : 32'h0;
  end
  // TX holding register; the slot is free in the same cycle the UART accepts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      tx_data <= 8'h0;
    end else if (wr_tx && tx_free) begin
      tx_valid <= 1'b1;
      tx_data <= wdata[7:0];
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
  // counters and sticky overflow; CTR_RST wins over increment and new overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
      instret <= '0;
      overflow <= 1'b0;
    end else if (wr_ctr) begin
      cycle <= '0;
      instret <= '0;
      overflow <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      instret <= instret + 32'(inst_retired);
      if (rx_valid && full) overflow <= 1'b1;
    end
  end
  // registered load data, held between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else if (re) rdata <= rd_mux;
  end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped I/O controller that lets the RISC-V core drive the UART transceiver through loads and stores. It decodes the CPU data-port address, holds one TX byte until the transmitter accepts it, and buffers received bytes in a small FIFO. It also provides the cycle and retired-instruction counters. It sits between the core's data-memory port and the uart block.

Parameters:
RX_DEPTH, 4, RX FIFO entries; must be a power of two and at least 2.
IO_BASE, 32'h8000_0000, base address of the I/O window.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
addr  input  32  CPU data address
wdata  input  32  CPU store data
we  input  1  store strobe, one cycle
re  input  1  load strobe, one cycle
rdata  output  32  load data, registered
inst_retired  input  1  pulses once per retired instruction
tx_data  output  8  byte to transmitter (uart.data_in)
tx_valid  output  1  uart.data_in_valid
tx_ready  input  1  uart.data_in_ready
rx_data  input  8  uart.data_out
rx_valid  input  1  uart.data_out_valid
rx_ready  output  1  uart.data_out_ready

Behaviour:
- Reset (reset low, asynchronous): rdata=0, tx_valid=0, tx_data=0, FIFO empty, overflow=0, both counters=0. rx_ready=1 after reset because the FIFO is empty.
- Register map, by offset from IO_BASE. A register is selected only when addr[31:8]==IO_BASE[31:8].
  - 0x00 STATUS (read-only): bit0 = tx_space (!tx_valid), bit1 = rx_avail (FIFO not empty), bit2 = overflow (sticky). Upper bits 0.
  - 0x04 RX_DATA (read): {24'b0, FIFO head}. A read when the FIFO is non-empty pops one entry. A read when empty returns 0 and does not pop.
  - 0x08 TX_DATA (write): wdata[7:0] is loaded into the holding register and tx_valid is set. A write while tx_valid=1 is dropped; the held byte is unchanged.
  - 0x10 CYCLE (read): free-running 32-bit count, incremented every clk, wraps 0xFFFF_FFFF -> 0.
  - 0x14 INSTRET (read): 32-bit count, +1 on each cycle with inst_retired=1, wraps.
  - 0x18 CTR_RST (write): zeroes both counters on the next edge. This write also clears overflow. Counters resume from 0 on the following cycle.
- Any unmapped offset: reads return 0, writes are ignored.
- Read latency: 1 cycle. rdata is updated on the edge after re=1 and holds its value until the next re. re with an unselected address drives rdata=0.
- TX handshake:
  - tx_valid falls on the edge where tx_valid && tx_ready.
  - A store in the same cycle as that acceptance is accepted: the new byte is loaded and tx_valid stays 1. The rule is that the slot counts as free when tx_ready is high.
- RX handshake:
  - rx_ready = !fifo_full.
  - A byte is pushed on the edge where rx_valid && rx_ready.
  - Full FIFO with rx_valid=1 sets overflow. The uart receiver keeps its byte; nothing is lost inside this block.
- Simultaneous push and pop with the FIFO full: the pop frees a slot, but rx_ready was already 0 (it is combinational from full), so no push occurs that cycle.
- Simultaneous push and pop otherwise: occupancy is unchanged and the head advances.
- Simultaneous re and we are impossible on a 3-stage core. If both occur, we takes effect and re still returns data.
- Counters run during reset release. STATUS read-back reflects state before the edge.
- Reset asserted mid-transfer: the held TX byte and the FIFO contents are discarded immediately.

Decomposition:
- Package uart_mmio_pkg holds:
  - offset constants OFF_STATUS, OFF_RX, OFF_TX, OFF_CYCLE, OFF_INSTRET, OFF_CTR_RST;
  - STATUS bit indices;
  - IO_BASE default.
- One sub-module, uart_rx_fifo: parameterised depth, 8-bit data, push/pop/full/empty/head, pointers with an extra wrap bit, asynchronous active-low reset.
- Top-level logic covers decode, the TX holding register, counters and the rdata register.

Test Plan:
- Reset, then read STATUS -> rdata=0x1 one cycle later; CYCLE read 10 cycles after release -> value in range 9..11, and successive reads strictly increase.
- Store 0x41 to 0x08 with tx_ready=0 for 5 cycles, then store 0x42 -> tx_data stays 0x41 and tx_valid=1. Raise tx_ready for 1 cycle -> tx_valid=0. A store of 0x43 in the acceptance cycle -> tx_data=0x43, tx_valid=1.
- Push 0x11, 0x22, 0x33 via rx_valid, read 0x04 three times -> 0x11, 0x22, 0x33. A fourth read returns 0 and STATUS bit1=0.
- Push RX_DEPTH+1 bytes with no reads -> rx_ready=0 after the 4th push and STATUS=0x7. Write CTR_RST -> STATUS bit2 clears.
- Pulse inst_retired 7 times, read INSTRET -> 7. Write CTR_RST, read CYCLE and INSTRET next -> both small (≤2 and 0).
- Read offset 0x20 and address 0x7000_0004 -> rdata=0. Assert reset mid-TX (tx_valid=1) -> tx_valid=0 asynchronously, FIFO empty.
